// File: rtl/regfile_cmd_master_if.sv
// Command/response and register-file bus bundle for regfile_cmd_master.
// Handshakes: a beat transfers on a rising clock edge where valid && ready; valid holds with stable payload until then.
interface regfile_cmd_master_if #(
   parameter int INDEX_WIDTH = 7
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_is_read;
   logic [INDEX_WIDTH-1:0] cmd_index;
   logic [31:0]            cmd_data;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [INDEX_WIDTH-1:0] rsp_index;
   logic [31:0]            rsp_data;
   logic                   write;
   logic                   read;
   logic [32:0]            register_index;
   logic [31:0]            register_data_in;
   logic [31:0]            register_data_out;

   modport master (
      input  cmd_valid, cmd_is_read, cmd_index, cmd_data, rsp_ready, register_data_out,
      output cmd_ready, rsp_valid, rsp_index, rsp_data, write, read, register_index,
             register_data_in
   );

   modport slave (
      output cmd_valid, cmd_is_read, cmd_index, cmd_data, rsp_ready, register_data_out,
      input  cmd_ready, rsp_valid, rsp_index, rsp_data, write, read, register_index,
             register_data_in
   );
endinterface

// File: rtl/regfile_cmd_master.sv
// Register-file bus master: queues host read/write commands in a FIFO, issues them
// in program order, and returns read data on a valid/ready response channel.
module regfile_cmd_master #(
   parameter int FIFO_DEPTH   = 8,
   parameter int INDEX_WIDTH  = 7,
   parameter int READ_LATENCY = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   regfile_cmd_master_if.master bus,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;

   logic [INDEX_WIDTH-1:0] idx_mem  [FIFO_DEPTH];
   logic [31:0]            data_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  rd_mem;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW:0]            count;
   state_t                 state;
   logic [CW-1:0]          lat_cnt;
   logic                   push;
   logic                   pop;

   assign bus.cmd_ready = (count < (PW+1)'(FIFO_DEPTH));
   assign push          = bus.cmd_valid && bus.cmd_ready;
   // Pop decision uses the registered count, so a fresh entry waits one cycle.
   assign pop           = (state == IDLE) && (count != '0);
   assign busy          = (count != '0) || (state != IDLE) || bus.write;
   assign state_dbg     = state;

   always_ff @(posedge clock) begin
      if (push) begin
         idx_mem[wr_ptr]  <= bus.cmd_index;
         data_mem[wr_ptr] <= bus.cmd_data;
         rd_mem[wr_ptr]   <= bus.cmd_is_read;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                <= IDLE;
         lat_cnt              <= '0;
         bus.write            <= 1'b0;
         bus.read             <= 1'b0;
         bus.register_index   <= '0;
         bus.register_data_in <= '0;
         bus.rsp_valid        <= 1'b0;
         bus.rsp_data         <= '0;
         bus.rsp_index        <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.write <= 1'b0;
               bus.read  <= 1'b0;
               if (count != '0) begin
                  bus.register_index <= 33'(idx_mem[rd_ptr]);
                  if (rd_mem[rd_ptr]) begin
                     bus.read <= 1'b1;
                     lat_cnt  <= CW'(READ_LATENCY - 1);
                     state    <= READ_WAIT;
                  end else begin
                     bus.write            <= 1'b1;
                     bus.register_data_in <= data_mem[rd_ptr];
                  end
               end
            end
            READ_WAIT: begin
               // read and register_index stay put; the register file gates data with read.
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - CW'(1);
               end else begin
                  bus.rsp_data  <= bus.register_data_out;
                  bus.rsp_index <= bus.register_index[INDEX_WIDTH-1:0];
                  bus.read      <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Bench for regfile_cmd_master: register-file environment, command-level reference
// model with expected queues, directed scenarios plus a randomized run.
module tb_regfile_cmd_master;
   localparam int IW = 7;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b1;
   logic        busy, busy3;
   logic [1:0]  state_dbg, state_dbg3;
   int          checks   = 0;
   int          failures = 0;

   regfile_cmd_master_if #(.INDEX_WIDTH(IW)) bus ();
   regfile_cmd_master_if #(.INDEX_WIDTH(IW)) bus3 ();

   regfile_cmd_master #(.FIFO_DEPTH(8), .INDEX_WIDTH(IW), .READ_LATENCY(1)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   regfile_cmd_master #(.FIFO_DEPTH(8), .INDEX_WIDTH(IW), .READ_LATENCY(3)) dut3 (
      .clock     (clock),
      .reset_n   (reset_n),
      .bus       (bus3),
      .busy      (busy3),
      .state_dbg (state_dbg3)
   );

   always #5 clock = ~clock;

   // ---------------- environment: register file and response consumer
   logic [31:0] regs [128];
   int unsigned cyc = 0;
   int          ready_mode = 1;   // 0 low, 1 high, 2 random
   logic        rand_bit = 1'b1;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 128; i++) regs[i] <= 32'h0;
      end else if (bus.write) begin
         regs[bus.register_index[IW-1:0]] <= bus.register_data_in;
      end
   end

   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) begin
      #1;
      rand_bit = ($urandom_range(0, 3) != 0);
   end

   assign bus.register_data_out  = bus.read ? regs[bus.register_index[IW-1:0]] : 32'h0;
   assign bus.rsp_ready          = (ready_mode == 2) ? rand_bit : (ready_mode == 1);
   assign bus3.register_data_out = bus3.read ? (32'hC0DE_0000 + cyc) : 32'h0;

   // ---------------- reference model and scoreboard
   logic [31:0]    model_regs [128];
   logic [IW+31:0] exp_q  [$];   // expected read responses {index, data}
   logic [IW+31:0] exp_wq [$];   // expected write strobes {index, data}
   int             write_run     = 0;
   int             max_write_run = 0;

   always @(negedge clock) begin : monitor
      logic [IW+31:0] e;
      if (reset_n) begin
         if (bus.write) begin
            write_run++;
            if (write_run > max_write_run) max_write_run = write_run;
            checks++;
            if (exp_wq.size() == 0) begin
               failures++;
               $display("FAIL write_unexpected got idx=%0d data=%h want none",
                        bus.register_index, bus.register_data_in);
            end else begin
               e = exp_wq.pop_front();
               if (bus.register_index !== 33'(e[IW+31:32]) || bus.register_data_in !== e[31:0]) begin
                  failures++;
                  $display("FAIL write_strobe got idx=%0d data=%h want idx=%0d data=%h",
                           bus.register_index, bus.register_data_in, e[IW+31:32], e[31:0]);
               end
            end
         end else begin
            write_run = 0;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected got idx=%0d data=%h want none",
                        bus.rsp_index, bus.rsp_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.rsp_index !== e[IW+31:32] || bus.rsp_data !== e[31:0]) begin
                  failures++;
                  $display("FAIL rsp_order got idx=%0d data=%h want idx=%0d data=%h",
                           bus.rsp_index, bus.rsp_data, e[IW+31:32], e[31:0]);
               end
            end
         end
         if (bus.write || bus.read) begin
            checks++;
            if (bus.write && bus.read) begin
               failures++;
               $display("FAIL rd_wr_exclusive got write=1 read=1 want not both");
            end
         end
      end
   end

   // ---------------- driver tasks
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_wq.delete();
      for (int i = 0; i < 128; i++) model_regs[i] = 32'h0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_cmd(input bit rd, input logic [IW-1:0] idx, input logic [31:0] data);
      int guard = 0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_is_read = rd;
      bus.cmd_index   = idx;
      bus.cmd_data    = data;
      @(negedge clock);
      while (!bus.cmd_ready && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         failures++;
         $display("FAIL push_timeout got cmd_ready=0 want 1 within 300 cycles");
      end else if (rd) begin
         exp_q.push_back({idx, model_regs[idx]});
      end else begin
         model_regs[idx] = data;
         exp_wq.push_back({idx, data});
      end
      @(posedge clock);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && exp_wq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clock);
      #1;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      int g;
      #1 reset_n = 1'b0;
      #2;
      checks++;
      if (bus.write !== 1'b0 || bus.read !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.register_index !== 33'h0 || bus.register_data_in !== 32'h0 ||
          bus.rsp_data !== 32'h0 || bus.rsp_index !== 7'h0) begin
         failures++;
         $display("FAIL reset_outputs got wr=%b rd=%b rv=%b idx=%h din=%h rdata=%h ridx=%h want all 0",
                  bus.write, bus.read, bus.rsp_valid, bus.register_index,
                  bus.register_data_in, bus.rsp_data, bus.rsp_index);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, busy);
      end
      clear_model();
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      idle(2);

      // reset while a read is on the bus
      ready_mode = 0;
      push_cmd(1'b1, 7'd3, 32'h0);
      g = 0;
      @(negedge clock);
      while (!bus.read && g < 10) begin
         @(negedge clock);
         g++;
      end
      checks++;
      if (g >= 10) begin
         failures++;
         $display("FAIL midread_issue got read=0 want 1 within 10 cycles");
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.read !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL midread_drop got read=%b rsp_valid=%b want 0 0", bus.read, bus.rsp_valid);
      end
      clear_model();
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      ready_mode = 1;
      idle(3);
      @(negedge clock);
      checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.read !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got cmd_ready=%b busy=%b rsp_valid=%b read=%b want 1 0 0 0",
                  bus.cmd_ready, busy, bus.rsp_valid, bus.read);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_write_burst();
      bit ok;
      ready_mode    = 1;
      max_write_run = 0;
      push_cmd(1'b0, 7'd1, 32'h00FF_00FF);
      push_cmd(1'b0, 7'd2, 32'h0000_0001);
      push_cmd(1'b0, 7'd3, 32'h0000_0280);
      wait_drain(50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL burst_drain got pending=%0d want 0", exp_wq.size());
      end
      checks++;
      if (max_write_run != 3) begin
         failures++;
         $display("FAIL burst_run got %0d consecutive write cycles want 3", max_write_run);
      end
      checks++;
      if (regs[3] !== 32'h0000_0280 || regs[1] !== 32'h00FF_00FF) begin
         failures++;
         $display("FAIL burst_regfile got r1=%h r3=%h want 00ff00ff 00000280", regs[1], regs[3]);
      end
   endtask

   task automatic test_write_then_read();
      bit ok;
      int g = 0;
      ready_mode = 1;
      push_cmd(1'b0, 7'd5, 32'hDEAD_BEEF);
      push_cmd(1'b1, 7'd5, 32'h0);
      @(negedge clock);
      while (!bus.read && g < 10) begin
         @(negedge clock);
         g++;
      end
      @(negedge clock);
      checks++;
      if (bus.read !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_index !== 7'd5 ||
          bus.rsp_data !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL wr_then_rd got read=%b rsp_valid=%b idx=%0d data=%h want 0 1 5 deadbeef",
                  bus.read, bus.rsp_valid, bus.rsp_index, bus.rsp_data);
      end
      wait_drain(50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wtr_drain got pending=%0d want 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int g = 0;
      logic [IW+31:0] want;
      ready_mode = 0;
      want = {7'd1, model_regs[1]};
      push_cmd(1'b1, 7'd1, 32'h0);
      push_cmd(1'b0, 7'd9, $urandom);
      @(negedge clock);
      while (!bus.rsp_valid && g < 10) begin
         @(negedge clock);
         g++;
      end
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || {bus.rsp_index, bus.rsp_data} !== want || bus.write !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc%0d got rv=%b idx=%0d data=%h wr=%b want 1 %0d %h 0",
                     i, bus.rsp_valid, bus.rsp_index, bus.rsp_data, bus.write,
                     want[IW+31:32], want[31:0]);
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      ready_mode = 1;
      wait_drain(50, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_drain got pending=%0d want 0", exp_q.size() + exp_wq.size());
      end
   endtask

   task automatic test_fifo_full();
      bit ok;
      ready_mode = 0;
      // The first read leaves the FIFO for the bus, so nine pushes fill eight slots.
      for (int i = 0; i < 9; i++) begin
         push_cmd(1'b1, IW'($urandom_range(0, 15)), 32'h0);
         if (i == 7) begin
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
               failures++;
               $display("FAIL full_early got cmd_ready=0 want 1 at count=7");
            end
         end
      end
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready got cmd_ready=1 want 0 at count=8");
      end
      bus.cmd_valid   = 1'b1;
      bus.cmd_is_read = 1'b1;
      bus.cmd_index   = 7'd99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (bus.cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_refuse got cmd_ready=1 want 0");
         end
      end
      @(posedge clock);
      #1;
      bus.cmd_valid = 1'b0;
      ready_mode    = 1;
      wait_drain(100, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_drain got pending=%0d want 0", exp_q.size());
      end
      idle(5);
   endtask

   task automatic test_random();
      bit ok;
      ready_mode = 2;
      for (int i = 0; i < 80; i++) begin
         push_cmd(1'($urandom_range(0, 1)), IW'($urandom_range(0, 7)), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      ready_mode = 1;
      wait_drain(500, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL random_drain got pending=%0d want 0", exp_q.size() + exp_wq.size());
      end
   endtask

   task automatic test_latency3();
      int          rd_cycles = 0;
      int unsigned first_cyc = 0;
      int          g = 0;
      bus3.rsp_ready   = 1'b1;
      bus3.cmd_valid   = 1'b1;
      bus3.cmd_is_read = 1'b1;
      bus3.cmd_index   = 7'd2;
      @(posedge clock);
      #1;
      bus3.cmd_valid = 1'b0;
      @(negedge clock);
      while (!bus3.rsp_valid && g < 30) begin
         if (bus3.read) begin
            if (rd_cycles == 0) first_cyc = cyc;
            rd_cycles++;
         end
         @(negedge clock);
         g++;
      end
      checks++;
      if (rd_cycles != 3) begin
         failures++;
         $display("FAIL lat3_read_len got %0d read cycles want 3", rd_cycles);
      end
      checks++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_index !== 7'd2 ||
          bus3.rsp_data !== 32'hC0DE_0000 + first_cyc + 2) begin
         failures++;
         $display("FAIL lat3_rsp got rv=%b idx=%0d data=%h want 1 2 %h",
                  bus3.rsp_valid, bus3.rsp_index, bus3.rsp_data, 32'hC0DE_0000 + first_cyc + 2);
      end
      idle(3);
      checks++;
      if (busy3 !== 1'b0 || bus3.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL lat3_idle got busy=%b rv=%b want 0 0", busy3, bus3.rsp_valid);
      end
   endtask

   initial begin
      bus.cmd_valid    = 1'b0;
      bus.cmd_is_read  = 1'b0;
      bus.cmd_index    = '0;
      bus.cmd_data     = '0;
      bus3.cmd_valid   = 1'b0;
      bus3.cmd_is_read = 1'b0;
      bus3.cmd_index   = '0;
      bus3.cmd_data    = '0;
      bus3.rsp_ready   = 1'b1;
      test_reset();
      test_write_burst();
      test_write_then_read();
      test_backpressure();
      test_fifo_full();
      test_random();
      test_latency3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want finish before 500000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
